// File: rtl/cpu_control_fsm.sv
// FETCH/LATCH/EXEC/LOAD_WB control for the 16-bit CR16-style datapath: 3 cycles per instruction, 4 for LOAD.
// No stalls; exactly one pc_en per instruction. Defining CTRL_PERF_EN adds the retire_count port.
module cpu_control_fsm #(
    parameter int PC_W = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] op,
    input  logic       r_or_i,
    input  logic [4:0] flags,
    output logic       ir_we,
    output logic       addr_sel,
    output logic       pc_en,
    output logic       pc_sel,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic       flags_we,
    output logic       mem_we,
    output logic       alu_b_sel,
    output logic       tx_strobe
`ifdef CTRL_PERF_EN
    ,
    output logic [PC_W-1:0] retire_count
`endif
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        LATCH   = 2'd1,
        EXEC    = 2'd2,
        LOAD_WB = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] op_hi, op_lo;
    logic       flg_c, flg_l, flg_f, flg_z, flg_n;
    logic       br_taken;
    logic       is_shift, is_io;

    assign op_hi = op[7:4];
    assign op_lo = op[3:0];
    assign {flg_c, flg_l, flg_f, flg_z, flg_n} = flags;

    assign is_shift = (op == 8'h84) || (op == 8'h86) || (op == 8'h4F) || (op == 8'h88);
    assign is_io    = (op == 8'h8C) || (op == 8'h8D) || (op == 8'h4A) || (op == 8'h4E);

    always_comb begin
        br_taken = 1'b0;
        case (op_lo)
            4'h0: br_taken = flg_z;
            4'h1: br_taken = !flg_z;
            4'h2: br_taken = flg_c;
            4'h3: br_taken = !flg_c;
            4'h4: br_taken = flg_l;
            4'h5: br_taken = !flg_l;
            4'h6: br_taken = flg_n;
            4'h7: br_taken = !flg_n;
            4'h8: br_taken = flg_f;
            4'h9: br_taken = !flg_f;
            4'hA: br_taken = !flg_l && !flg_z;
            4'hB: br_taken = flg_l || flg_z;
            4'hC: br_taken = !flg_n && !flg_z;
            4'hD: br_taken = flg_n || flg_z;
            4'hE: br_taken = 1'b1;
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_we     = 1'b0;
        addr_sel  = 1'b0;
        pc_en     = 1'b0;
        pc_sel    = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = 2'b00;
        flags_we  = 1'b0;
        mem_we    = 1'b0;
        alu_b_sel = 1'b0;
        tx_strobe = 1'b0;
        case (state_q)
            FETCH: begin
                state_d = LATCH;
            end
            LATCH: begin
                ir_we   = 1'b1;
                state_d = EXEC;
            end
            EXEC: begin
                state_d   = FETCH;
                alu_b_sel = r_or_i;
                // Specific opcodes first: several of them sit inside the I-type opcode ranges.
                if (op == 8'h40) begin
                    addr_sel = 1'b1;
                    state_d  = LOAD_WB;
                end else if (op == 8'h44) begin
                    addr_sel = 1'b1;
                    mem_we   = 1'b1;
                    pc_en    = 1'b1;
                end else if (op == 8'h8F) begin
                    tx_strobe = 1'b1;
                    pc_en     = 1'b1;
                end else if (op_hi == 4'hC) begin
                    pc_sel = br_taken;
                    pc_en  = 1'b1;
                end else if (is_shift) begin
                    reg_we = 1'b1;
                    pc_en  = 1'b1;
                end else if (is_io) begin
                    reg_we = 1'b1;
                    wb_sel = 2'b10;
                    pc_en  = 1'b1;
                end else if (op != 8'h00 && op_hi != 4'h8) begin
                    reg_we   = !((op == 8'h0B) || (op_hi == 4'hB));
                    flags_we = 1'b1;
                    pc_en    = 1'b1;
                end else begin
                    // NOP and unassigned 0x8? codes just advance the PC.
                    pc_en = 1'b1;
                end
            end
            LOAD_WB: begin
                addr_sel = 1'b1;
                reg_we   = 1'b1;
                wb_sel   = 2'b01;
                pc_en    = 1'b1;
                state_d  = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

`ifdef CTRL_PERF_EN
    logic [PC_W-1:0] retire_q, retire_d;

    always_comb begin
        retire_d = retire_q;
        if (pc_en) begin
            retire_d = retire_q + {{(PC_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_q <= '0;
        end else begin
            retire_q <= retire_d;
        end
    end

    assign retire_count = retire_q;
`endif

endmodule
